misc_input_stage: RTL and testbench
===================================

# misc_input_stage

- Upstream front end for the `misc` design mux.
- Synchronises the 42 raw pad inputs into `clk_i` and produces `io_in_buffered`.
- Debounces the 3-bit design-select strap and produces `design_sel_buffered`.
- Sequences `rst_override_n` so that the selected design sits in reset while the selection is changing, and for a fixed hold time after a new selection is committed.
- Drives `io_in_buffered`, `design_sel_buffered` and `rst_override_n` of `misc` directly.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1024: number of consecutive cycles the synchronised select must stay stable before it is committed. Range 2..65535.
- `RST_HOLD_CYCLES`, default 16: number of cycles `rst_override_n` stays low after a commit. Range 2..65535.

Ports:
- `clk_i`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `io_in`  in  42: raw pad inputs, asynchronous to `clk_i`.
- `design_sel`  in  3: raw design-select strap pins, asynchronous.
- `io_in_buffered`  out  42: `io_in` after a 2-flop synchroniser.
- `design_sel_buffered`  out  3: committed design selection; changes only on a commit.
- `rst_override_n`  out  1: active-low reset for the selected design; registered.
- `sel_commit`  out  1: one-cycle pulse in the cycle after `design_sel_buffered` is loaded.

## Operation

Reset (`rst_n` = 0), all values apply immediately:
- All synchroniser flops = 0.
- `io_in_buffered` = 0.
- `design_sel_buffered` = 0.
- `rst_override_n` = 0.
- `sel_commit` = 0.
- FSM state = DEBOUNCE, candidate `cand` = 0, counter `cnt` = 0.

Synchronisers:
- `io_in` and `design_sel` each pass through two flops.
- `sel_s` is the second-stage output of the `design_sel` synchroniser.
- No other filtering is applied to `io_in`.

FSM: 3 states, one shared 16-bit counter `cnt`. Every comparison uses the register values present before the clock edge.
- DEBOUNCE:
  - If `sel_s` != `cand`: `cand` <= `sel_s`, `cnt` <= 0.
  - Else if `cnt` == `DEBOUNCE_CYCLES`-1: `design_sel_buffered` <= `cand`, `sel_commit` <= 1, `cnt` <= 0, go to HOLD.
  - Else: `cnt` <= `cnt`+1.
- HOLD:
  - `sel_s` is ignored.
  - If `cnt` == `RST_HOLD_CYCLES`-1: go to RUN.
  - Else: `cnt`+1.
- RUN:
  - If `sel_s` != `design_sel_buffered`: `cand` <= `sel_s`, `cnt` <= 0, go to DEBOUNCE.
  - Otherwise stay in RUN.

Output rules:
- `rst_override_n` <= 1 exactly when the next state is RUN; it is 0 in DEBOUNCE and HOLD.
- `sel_commit` is 1 only in the single cycle following a commit edge.
- A commit always passes through HOLD, even when the committed value equals the previous `design_sel_buffered`. A glitch that returns to the old value therefore still produces a full reset sequence.

Boundary conditions:
- `cnt` never wraps; it is bounded by the parameter compare.
- `design_sel` changing during HOLD is ignored until RUN. RUN then detects the mismatch on its first cycle.
- `rst_n` asserted in any state returns the block to the reset values immediately. `design_sel_buffered` returns to 0 and the debounce restarts from scratch.

## Timing

`io_in_buffered` latency:
- Equals `io_in` sampled 2 rising edges earlier.

Commit latency from reset release, with `design_sel` held at v != 0:
- The synchroniser holds `sel_s` = 0 for the first 2 edges, and each of those edges advances `cnt` on candidate 0.
- The 3rd edge sees the mismatch and reloads (`cand` = v, `cnt` = 0).
- Commit happens on edge 3 + `DEBOUNCE_CYCLES`.
- `rst_override_n` rises on edge 3 + `DEBOUNCE_CYCLES` + `RST_HOLD_CYCLES`.

Commit latency from reset release, with `design_sel` held at 0:
- Commit happens on edge `DEBOUNCE_CYCLES`.
- `rst_override_n` rises on edge `DEBOUNCE_CYCLES` + `RST_HOLD_CYCLES`.

Select change while in RUN (new pin value lands on edge E):
- `sel_s` updates on edge E+2.
- `rst_override_n` falls on edge E+3.
- Commit happens on edge E+3+`DEBOUNCE_CYCLES`.
- `rst_override_n` rises on edge E+3+`DEBOUNCE_CYCLES`+`RST_HOLD_CYCLES`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=8 and `RST_HOLD_CYCLES`=4.

- **Reset values:** assert `rst_n`=0 mid-clock → all outputs 0 without waiting for an edge. Release with `design_sel`=3 → `design_sel_buffered`=3 and `sel_commit`=1 after edge 11; `sel_commit`=0 after edge 12; `rst_override_n`=1 after edge 15.
- **Select change in RUN:** while in RUN, change `design_sel` from 3 to 6 at edge E → `rst_override_n`=0 after E+3; `design_sel_buffered`=6 after E+11; `rst_override_n`=1 after E+15.
- **Bouncing select:** toggle `design_sel` between 4 and 5 every 3 cycles for 40 cycles, then hold at 5 → no commit while toggling; commit to 5 exactly 8 edges after the last reload; `rst_override_n` stays 0 throughout.
- **Glitch back to old value:** in RUN with 2, pulse `design_sel`=1 for 2 cycles → `rst_override_n` falls; commit to 2 with `sel_commit` pulse; `rst_override_n` returns to 1 after the 4-cycle hold.
- **Change during HOLD:** change `design_sel` from 3 to 7 during HOLD → `design_sel_buffered` stays 3 through HOLD; `rst_override_n` rises for exactly 1 cycle, then drops; commit to 7 follows.
- **IO synchroniser:** drive `io_in`=42'h2AAAAAAAAAA at edge E → `io_in_buffered` equals it after E+2, independent of FSM state. Assert reset during HOLD → `io_in_buffered`=0 and FSM in DEBOUNCE immediately.

Source files
------------

// File: rtl/misc_input_stage.sv
// Input front end for the misc design mux: synchronises pad inputs, debounces the
// design-select strap and holds the selected design in reset around each selection change.
module misc_input_stage #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [41:0] io_in,
    input  logic [2:0]  design_sel,
    output logic [41:0] io_in_buffered,
    output logic [2:0]  design_sel_buffered,
    output logic        rst_override_n,
    output logic        sel_commit
);

    typedef enum logic [1:0] {
        DEBOUNCE = 2'd0,
        HOLD     = 2'd1,
        RUN      = 2'd2
    } state_t;

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);

    logic [41:0] io_sync_p0;
    logic [2:0]  sel_sync_p0;
    logic [2:0]  sel_s;
    state_t      state;
    logic [2:0]  cand;
    logic [15:0] cnt;

    // Two-flop synchronisers; the second stage of io_in is the output itself
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            io_sync_p0     <= '0;
            io_in_buffered <= '0;
            sel_sync_p0    <= '0;
            sel_s          <= '0;
        end else begin
            io_sync_p0     <= io_in;
            io_in_buffered <= io_sync_p0;
            sel_sync_p0    <= design_sel;
            sel_s          <= sel_sync_p0;
        end
    end

    // Select sequencer; rst_override_n is registered high only when the next state is RUN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state               <= DEBOUNCE;
            cand                <= '0;
            cnt                 <= '0;
            design_sel_buffered <= '0;
            rst_override_n      <= 1'b0;
            sel_commit          <= 1'b0;
        end else begin
            sel_commit <= 1'b0;
            case (state)
                DEBOUNCE: begin
                    rst_override_n <= 1'b0;
                    if (sel_s != cand) begin
                        cand <= sel_s;
                        cnt  <= '0;
                    end else if (cnt == DEB_LAST) begin
                        design_sel_buffered <= cand;
                        sel_commit          <= 1'b1;
                        cnt                 <= '0;
                        state               <= HOLD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state          <= RUN;
                        rst_override_n <= 1'b1;
                    end else begin
                        cnt            <= cnt + 16'd1;
                        rst_override_n <= 1'b0;
                    end
                end
                RUN: begin
                    if (sel_s != design_sel_buffered) begin
                        cand           <= sel_s;
                        cnt            <= '0;
                        state          <= DEBOUNCE;
                        rst_override_n <= 1'b0;
                    end else begin
                        rst_override_n <= 1'b1;
                    end
                end
                default: begin
                    state          <= DEBOUNCE;
                    rst_override_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_misc_input_stage.sv
// Bench for misc_input_stage: cycle scoreboard against a behavioural model plus
// edge-indexed expectation tables for the select sequencing scenarios.
module tb_misc_input_stage;

    localparam int DEB = 8;
    localparam int HLD = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [41:0] io_in = '0;
    logic [2:0]  design_sel = '0;
    logic [41:0] io_in_buffered;
    logic [2:0]  design_sel_buffered;
    logic        rst_override_n;
    logic        sel_commit;

    misc_input_stage #(
        .DEBOUNCE_CYCLES(DEB),
        .RST_HOLD_CYCLES(HLD)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .io_in(io_in),
        .design_sel(design_sel),
        .io_in_buffered(io_in_buffered),
        .design_sel_buffered(design_sel_buffered),
        .rst_override_n(rst_override_n),
        .sel_commit(sel_commit)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [41:0] io1, io2;
        logic [2:0]  s1, s2, cand, dsb;
        int          st, cnt;
        logic        rst_o, com;
    } mdl_t;

    typedef struct {
        int         at;
        logic [2:0] sel;
        logic [2:0] dsb;
        logic       rst_o;
        logic       com;
    } vec_t;

    mdl_t mdl;
    mdl_t sb_q[$];
    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t tbl_c[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_n = 0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.io1 = '0; r.io2 = '0; r.s1 = '0; r.s2 = '0;
        r.cand = '0; r.dsb = '0; r.st = 0; r.cnt = 0;
        r.rst_o = 1'b0; r.com = 1'b0;
        return r;
    endfunction

    // st: 0 = debounce, 1 = hold, 2 = run
    function automatic mdl_t mdl_step(input mdl_t m, input logic [41:0] io, input logic [2:0] sel);
        mdl_t n;
        n = m;
        n.io1 = io;
        n.io2 = m.io1;
        n.s1  = sel;
        n.s2  = m.s1;
        n.com = 1'b0;
        if (m.st == 0) begin
            if (m.s2 != m.cand) begin
                n.cand = m.s2;
                n.cnt  = 0;
            end else if (m.cnt == DEB - 1) begin
                n.dsb = m.cand;
                n.com = 1'b1;
                n.cnt = 0;
                n.st  = 1;
            end else begin
                n.cnt = m.cnt + 1;
            end
        end else if (m.st == 1) begin
            if (m.cnt == HLD - 1) n.st = 2;
            else n.cnt = m.cnt + 1;
        end else begin
            if (m.s2 != m.dsb) begin
                n.cand = m.s2;
                n.cnt  = 0;
                n.st   = 0;
            end
        end
        n.rst_o = (n.st == 2);
        return n;
    endfunction

    function automatic logic [41:0] rnd_io();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[41:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic cycle(input logic [2:0] sel, input logic [41:0] io);
        mdl_t e;
        design_sel = sel;
        io_in      = io;
        e = rst_n ? mdl_step(mdl, io, sel) : mdl_reset();
        mdl = e;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        edge_n++;
        e = sb_q.pop_front();
        chk("sb_io", 64'(io_in_buffered), 64'(e.io2));
        chk("sb_dsb", 64'(design_sel_buffered), 64'(e.dsb));
        chk("sb_rst", 64'(rst_override_n), 64'(e.rst_o));
        chk("sb_commit", 64'(sel_commit), 64'(e.com));
    endtask

    task automatic apply(input vec_t v);
        while (edge_n < v.at) cycle(v.sel, rnd_io());
        chk($sformatf("e%0d_dsb", v.at), 64'(design_sel_buffered), 64'(v.dsb));
        chk($sformatf("e%0d_rst", v.at), 64'(rst_override_n), 64'(v.rst_o));
        chk($sformatf("e%0d_commit", v.at), 64'(sel_commit), 64'(v.com));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_io"}, 64'(io_in_buffered), 64'd0);
        chk({nm, "_dsb"}, 64'(design_sel_buffered), 64'd0);
        chk({nm, "_rst"}, 64'(rst_override_n), 64'd0);
        chk({nm, "_commit"}, 64'(sel_commit), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] bsel;

        // Edges counted from reset release with design_sel = 3
        tbl_a.push_back('{10, 3'd3, 3'd0, 1'b0, 1'b0});
        tbl_a.push_back('{11, 3'd3, 3'd3, 1'b0, 1'b1});
        tbl_a.push_back('{12, 3'd3, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{14, 3'd3, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{15, 3'd3, 3'd3, 1'b1, 1'b0});
        tbl_a.push_back('{20, 3'd3, 3'd3, 1'b1, 1'b0});
        // Select change 3 -> 6 in RUN, pin lands at edge 20
        tbl_a.push_back('{22, 3'd6, 3'd3, 1'b1, 1'b0});
        tbl_a.push_back('{23, 3'd6, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{30, 3'd6, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{31, 3'd6, 3'd6, 1'b0, 1'b1});
        tbl_a.push_back('{34, 3'd6, 3'd6, 1'b0, 1'b0});
        tbl_a.push_back('{35, 3'd6, 3'd6, 1'b1, 1'b0});
        tbl_a.push_back('{40, 3'd6, 3'd6, 1'b1, 1'b0});
        // Two-cycle glitch to 1 and back to 6
        tbl_a.push_back('{42, 3'd1, 3'd6, 1'b1, 1'b0});
        tbl_a.push_back('{43, 3'd6, 3'd6, 1'b0, 1'b0});
        tbl_a.push_back('{52, 3'd6, 3'd6, 1'b0, 1'b0});
        tbl_a.push_back('{53, 3'd6, 3'd6, 1'b0, 1'b1});
        tbl_a.push_back('{54, 3'd6, 3'd6, 1'b0, 1'b0});
        tbl_a.push_back('{56, 3'd6, 3'd6, 1'b0, 1'b0});
        tbl_a.push_back('{57, 3'd6, 3'd6, 1'b1, 1'b0});
        // Change to 3, then to 7 while in HOLD
        tbl_a.push_back('{60, 3'd6, 3'd6, 1'b1, 1'b0});
        tbl_a.push_back('{63, 3'd3, 3'd6, 1'b0, 1'b0});
        tbl_a.push_back('{71, 3'd3, 3'd3, 1'b0, 1'b1});
        tbl_a.push_back('{72, 3'd3, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{74, 3'd7, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{75, 3'd7, 3'd3, 1'b1, 1'b0});
        tbl_a.push_back('{76, 3'd7, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{83, 3'd7, 3'd3, 1'b0, 1'b0});
        tbl_a.push_back('{84, 3'd7, 3'd7, 1'b0, 1'b1});
        tbl_a.push_back('{87, 3'd7, 3'd7, 1'b0, 1'b0});
        tbl_a.push_back('{88, 3'd7, 3'd7, 1'b1, 1'b0});
        // After bouncing 4/5 over edges 89..128, last reload at 130
        tbl_b.push_back('{137, 3'd5, 3'd7, 1'b0, 1'b0});
        tbl_b.push_back('{138, 3'd5, 3'd5, 1'b0, 1'b1});
        tbl_b.push_back('{141, 3'd5, 3'd5, 1'b0, 1'b0});
        tbl_b.push_back('{142, 3'd5, 3'd5, 1'b1, 1'b0});
        tbl_b.push_back('{145, 3'd5, 3'd5, 1'b1, 1'b0});
        tbl_b.push_back('{148, 3'd6, 3'd5, 1'b0, 1'b0});
        tbl_b.push_back('{156, 3'd6, 3'd6, 1'b0, 1'b1});
        // Restart after reset with design_sel = 0
        tbl_c.push_back('{7, 3'd0, 3'd0, 1'b0, 1'b0});
        tbl_c.push_back('{8, 3'd0, 3'd0, 1'b0, 1'b1});
        tbl_c.push_back('{11, 3'd0, 3'd0, 1'b0, 1'b0});
        tbl_c.push_back('{12, 3'd0, 3'd0, 1'b1, 1'b0});

        mdl = mdl_reset();
        for (int i = 0; i < 3; i++) cycle(3'd3, rnd_io());
        chk_all_zero("in_reset");
        #4;
        rst_n  = 1'b1;
        edge_n = 0;

        for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i]);

        for (int k = 0; k < 40; k++) begin
            bsel = ((k / 3) % 2 == 0) ? 3'd4 : 3'd5;
            cycle(bsel, rnd_io());
            chk("bounce_commit", 64'(sel_commit), 64'd0);
            if (edge_n >= 91) chk("bounce_rst", 64'(rst_override_n), 64'd0);
        end

        for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i]);

        cycle(3'd6, 42'h2AAAAAAAAAA);
        cycle(3'd6, 42'h2AAAAAAAAAA);
        chk("io_sync", 64'(io_in_buffered), 64'h2AAAAAAAAAA);
        chk("hold_dsb", 64'(design_sel_buffered), 64'd6);

        // Asynchronous reset in the middle of HOLD
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        mdl = mdl_reset();
        sb_q.delete();
        design_sel = 3'd0;
        io_in      = rnd_io();
        #1;
        rst_n  = 1'b1;
        edge_n = 0;

        for (int i = 0; i < tbl_c.size(); i++) apply(tbl_c[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
